// File: rtl/vga_pkg.sv
// Shared VGA timing types, default 640x480 timing, totals helpers and colour constants.
package vga_pkg;

  typedef struct packed {
    logic [10:0] h_active;
    logic [10:0] h_fp;
    logic [10:0] h_sync;
    logic [10:0] h_bp;
    logic [10:0] v_active;
    logic [10:0] v_fp;
    logic [10:0] v_sync;
    logic [10:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h_active: 11'd640, h_fp: 11'd16, h_sync: 11'd96, h_bp: 11'd48,
    v_active: 11'd480, v_fp: 11'd10, v_sync: 11'd2,  v_bp: 11'd33
  };

  typedef enum logic [1:0] {
    PAT_FB      = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_BORDER  = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;

  function automatic int h_total(input vga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset to a per-bit reset value.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_scan_fb_reader.sv
// VGA scan engine with incremental framebuffer addressing and RAM-latency-aligned sync/blank.
// Optional test-pattern generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scan_fb_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = int'(VGA_640x480.h_active),
  parameter int H_FP        = int'(VGA_640x480.h_fp),
  parameter int H_SYNC      = int'(VGA_640x480.h_sync),
  parameter int H_BP        = int'(VGA_640x480.h_bp),
  parameter int V_ACTIVE    = int'(VGA_640x480.v_active),
  parameter int V_FP        = int'(VGA_640x480.v_fp),
  parameter int V_SYNC      = int'(VGA_640x480.v_sync),
  parameter int V_BP        = int'(VGA_640x480.v_bp),
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 19,
  parameter int COLOR_W     = 12
) (
  input  logic               pixel_clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  fb_addr,
  input  logic [COLOR_W-1:0] fb_rdata,
  output logic [COLOR_W-1:0] rgb,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [10:0]        draw_x,
  output logic [10:0]        draw_y,
  output logic               frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic [1:0]         pattern_sel
`endif
);

  localparam vga_timing_t TIMING = '{
    h_active: 11'(H_ACTIVE), h_fp: 11'(H_FP), h_sync: 11'(H_SYNC), h_bp: 11'(H_BP),
    v_active: 11'(V_ACTIVE), v_fp: 11'(V_FP), v_sync: 11'(V_SYNC), v_bp: 11'(V_BP)
  };
  localparam logic [10:0] H_LAST     = 11'(h_total(TIMING) - 1);
  localparam logic [10:0] V_LAST     = 11'(v_total(TIMING) - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HS_ON      = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON      = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam int          SW         = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam logic [SW-1:0]     S_MAX  = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [2:0]  SYNC_IDLE  = {~HS_POL, ~VS_POL, 1'b1};

  logic              r_run;
  logic [10:0]       r_h, r_v;
  logic [SW-1:0]     r_sx, r_sy;
  logic [ADDR_W-1:0] r_line_base, r_addr;
  logic [2:0]        r_sync_out;
  logic [COLOR_W-1:0] r_rgb;
  logic              w_h_wrap, w_v_wrap, w_active, w_hs_on, w_vs_on;
  logic [2:0]        w_sync_in, w_sync_d;
  logic [COLOR_W-1:0] w_color;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_on  = (r_h >= HS_ON) && (r_h < HS_OFF);
  assign w_vs_on  = (r_v >= VS_ON) && (r_v < VS_OFF);

  // r_run holds the counters at (0,0) for one cycle after reset so frame_start is seen
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      r_h <= w_h_wrap ? '0 : r_h + 11'd1;
      if (w_h_wrap) r_v <= w_v_wrap ? '0 : r_v + 11'd1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_sx        <= '0;
      r_sy        <= '0;
      r_line_base <= '0;
      r_addr      <= '0;
    end else if (r_run) begin
      if (w_h_wrap && w_v_wrap) begin
        r_sx        <= '0;
        r_sy        <= '0;
        r_line_base <= '0;
        r_addr      <= '0;
      end else if (w_active) begin
        if (r_h == H_ACT_LAST) begin
          r_sx <= '0;
          if (r_v == V_ACT_LAST) begin
            r_sy        <= '0;
            r_line_base <= '0;
            r_addr      <= '0;
          end else if (r_sy != S_MAX) begin
            r_sy   <= r_sy + 1'b1;
            r_addr <= r_line_base;
          end else begin
            r_sy        <= '0;
            r_line_base <= r_line_base + FB_W_A;
            r_addr      <= r_line_base + FB_W_A;
          end
        end else begin
          r_sx <= (r_sx == S_MAX) ? '0 : r_sx + 1'b1;
          if (r_sx == S_MAX) r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign w_sync_in = r_run ? {(w_hs_on ? HS_POL : ~HS_POL), (w_vs_on ? VS_POL : ~VS_POL), ~w_active}
                           : SYNC_IDLE;

  // Depth MEM_LATENCY lines blank up with fb_rdata; the output register adds the final stage.
  vga_delay_line #(.WIDTH(3), .DEPTH(MEM_LATENCY), .RST_VAL(SYNC_IDLE)) u_sync_dly (
    .i_clk (pixel_clk),
    .i_rst (rst),
    .i_d   (w_sync_in),
    .o_q   (w_sync_d)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);
  logic [10:0]        r_bar_px;
  logic [2:0]         r_bar;
  logic [COLOR_W-1:0] w_pat;
  logic [COLOR_W:0]   w_pat_d;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_bar_px <= '0;
      r_bar    <= '0;
    end else if (!r_run || w_h_wrap) begin
      r_bar_px <= '0;
      r_bar    <= '0;
    end else if (r_bar_px == BAR_LAST) begin
      r_bar_px <= '0;
      r_bar    <= r_bar + 3'd1;
    end else begin
      r_bar_px <= r_bar_px + 11'd1;
    end
  end

  always_comb begin
    w_pat = COLOR_W'(BLACK);
    case (pattern_e'(pattern_sel))
      PAT_BARS:    w_pat = COLOR_W'({{4{r_bar[2]}}, {4{r_bar[1]}}, {4{r_bar[0]}}});
      PAT_BORDER:  if (r_h == '0 || r_h == H_ACT_LAST || r_v == '0 || r_v == V_ACT_LAST)
                     w_pat = COLOR_W'(WHITE);
      PAT_CHECKER: w_pat = (r_h[3] ^ r_v[3]) ? COLOR_W'(BLACK) : COLOR_W'(WHITE);
      default:     w_pat = COLOR_W'(BLACK);
    endcase
  end

  // The framebuffer-select flag travels with the pattern so a pattern_sel change stays aligned.
  vga_delay_line #(.WIDTH(COLOR_W + 1), .DEPTH(MEM_LATENCY), .RST_VAL('0)) u_pat_dly (
    .i_clk (pixel_clk),
    .i_rst (rst),
    .i_d   ({(pattern_sel == 2'd0), w_pat}),
    .o_q   (w_pat_d)
  );

  assign w_color = w_pat_d[COLOR_W] ? fb_rdata : w_pat_d[COLOR_W-1:0];
`else
  assign w_color = fb_rdata;
`endif

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_sync_out <= SYNC_IDLE;
      r_rgb      <= '0;
    end else begin
      r_sync_out <= w_sync_d;
      r_rgb      <= w_sync_d[0] ? '0 : w_color;
    end
  end

  assign fb_addr     = r_addr;
  assign draw_x      = r_h;
  assign draw_y      = r_v;
  assign frame_start = r_run && (r_h == '0) && (r_v == '0);
  assign {hs, vs, blank} = r_sync_out;
  assign rgb         = r_rgb;

endmodule

// File: tb/tb_vga_scan_fb_reader.sv
// Directed bench: default 640x480 line timing plus two small-timing instances (S=0/L=2, S=1/L=1).
module tb_vga_scan_fb_reader;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 2, SHT = 24;
  localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 1, SVT = 12;
  localparam int SFT = SHT * SVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [18:0] addr_a, addr_b, addr_c;
  logic [11:0] rd_a, rd_b, rd_c, rb1, rgb_a, rgb_b, rgb_c;
  logic hs_a, vs_a, bl_a, fs_a, hs_b, vs_b, bl_b, fs_b, hs_c, vs_c, bl_c, fs_c;
  logic [10:0] dx_a, dy_a, dx_b, dy_b, dx_c, dy_c;
`ifdef VGA_TEST_PATTERN_EN
  logic [1:0] psel_a = 2'd0;
  logic [1:0] psel_0 = 2'd0;
`endif

  // RAM models with data = address
  always_ff @(posedge clk) begin
    rd_a <= addr_a[11:0];
    rb1  <= addr_b[11:0];
    rd_b <= rb1;
    rd_c <= addr_c[11:0];
  end

  vga_scan_fb_reader u_a (
    .pixel_clk(clk), .rst(rst_a), .fb_addr(addr_a), .fb_rdata(rd_a), .rgb(rgb_a),
    .hs(hs_a), .vs(vs_a), .blank(bl_a), .draw_x(dx_a), .draw_y(dy_a), .frame_start(fs_a)
`ifdef VGA_TEST_PATTERN_EN
    , .pattern_sel(psel_a)
`endif
  );

  vga_scan_fb_reader #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SCALE_SHIFT(0), .MEM_LATENCY(2)
  ) u_b (
    .pixel_clk(clk), .rst(rst_b), .fb_addr(addr_b), .fb_rdata(rd_b), .rgb(rgb_b),
    .hs(hs_b), .vs(vs_b), .blank(bl_b), .draw_x(dx_b), .draw_y(dy_b), .frame_start(fs_b)
`ifdef VGA_TEST_PATTERN_EN
    , .pattern_sel(psel_0)
`endif
  );

  vga_scan_fb_reader #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_SHIFT(1), .MEM_LATENCY(1)
  ) u_c (
    .pixel_clk(clk), .rst(rst_c), .fb_addr(addr_c), .fb_rdata(rd_c), .rgb(rgb_c),
    .hs(hs_c), .vs(vs_c), .blank(bl_c), .draw_x(dx_c), .draw_y(dy_c), .frame_start(fs_c)
`ifdef VGA_TEST_PATTERN_EN
    , .pattern_sel(psel_0)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int kg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    kg++;
  endtask

  function automatic int exp_addr(int k, int ha, int va, int ht, int vt, int s);
    int p, h, v, fbw;
    p = k % (ht * vt);
    h = p % ht;
    v = p / ht;
    fbw = ha >> s;
    if (v >= va) return 0;
    if (h < ha) return (v >> s) * fbw + (h >> s);
    if (v == va - 1) return 0;
    return ((v + 1) >> s) * fbw;
  endfunction

  task automatic chk_small(input string nm, input int k, input int s, input int lat, input bit pol,
                           input logic [18:0] addr, input logic [10:0] dx, input logic [10:0] dy,
                           input logic fs, input logic hs, input logic vs, input logic bl,
                           input logic [11:0] rgb);
    int p, j, pj, hj, vj;
    bit act, hon, von;
    p = k % SFT;
    chk({nm, ".addr"}, addr, exp_addr(k, SHA, SVA, SHT, SVT, s));
    chk({nm, ".draw_x"}, dx, p % SHT);
    chk({nm, ".draw_y"}, dy, p / SHT);
    chk({nm, ".frame_start"}, fs, p == 0);
    j = k - (lat + 1);
    if (j < 0) begin
      chk({nm, ".hs_idle"}, hs, !pol);
      chk({nm, ".vs_idle"}, vs, !pol);
      chk({nm, ".blank_idle"}, bl, 1);
      chk({nm, ".rgb_idle"}, rgb, 0);
    end else begin
      pj  = j % SFT;
      hj  = pj % SHT;
      vj  = pj / SHT;
      act = (hj < SHA) && (vj < SVA);
      hon = (hj >= SHA + SHF) && (hj < SHA + SHF + SHS);
      von = (vj >= SVA + SVF) && (vj < SVA + SVF + SVS);
      chk({nm, ".hs"}, hs, hon ? pol : !pol);
      chk({nm, ".vs"}, vs, von ? pol : !pol);
      chk({nm, ".blank"}, bl, !act);
      chk({nm, ".rgb"}, rgb, act ? (exp_addr(j, SHA, SVA, SHT, SVT, s) & 'hFFF) : 0);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall1, fall2, rise1, kb;
    logic prev_hs;
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst.blank", bl_a, 1);
    chk("rst.rgb", rgb_a, 0);
    chk("rst.hs", hs_a, 1);
    chk("rst.vs", vs_a, 1);
    chk("rst.fb_addr", addr_a, 0);
    chk("rst.draw_x", dx_a, 0);
    chk("rst.draw_y", dy_a, 0);
    chk("rst.frame_start", fs_a, 0);
    chk("rst.c_hs_pol1", hs_c, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    kg = -1; fall1 = -1; fall2 = -1; rise1 = -1;
    prev_hs = hs_a;
    for (int i = 0; i < 1700; i++) begin
      step();
      chk("a.draw_x", dx_a, kg % 800);
      chk("a.draw_y", dy_a, kg / 800);
      chk("a.addr", addr_a, exp_addr(kg, 640, 480, 800, 525, 0));
      chk("a.frame_start", fs_a, kg == 0);
      chk("a.vs", vs_a, 1);
      if (prev_hs && !hs_a) begin
        if (fall1 < 0) fall1 = kg;
        else if (fall2 < 0) fall2 = kg;
      end
      if (!prev_hs && hs_a && rise1 < 0) rise1 = kg;
      prev_hs = hs_a;
      if (kg == 1 || kg == 642) chk("a.blank_edge_hi", bl_a, 1);
      if (kg == 2 || kg == 641) chk("a.blank_edge_lo", bl_a, 0);
      if (kg == 102) chk("a.rgb_x100y0", rgb_a, 100);
      if (kg == 807) chk("a.rgb_x5y1", rgb_a, 645);
      if (kg == 700) chk("a.rgb_hblank", rgb_a, 0);
      chk_small("b", kg, 0, 2, 1'b0, addr_b, dx_b, dy_b, fs_b, hs_b, vs_b, bl_b, rgb_b);
      chk_small("c", kg, 1, 1, 1'b1, addr_c, dx_c, dy_c, fs_c, hs_c, vs_c, bl_c, rgb_c);
    end
    chk("a.hs_start", fall1, 658);
    chk("a.hs_width", rise1 - fall1, 96);
    chk("a.line_period", fall2 - fall1, 800);

    // mid-frame reset on the S=0 instance at pixel (5,3)
    while ((kg % SFT) != 77) step();
    chk("b.pre_rst_x", dx_b, 5);
    chk("b.pre_rst_y", dy_b, 3);
    rst_b = 1'b1;
    #1;
    chk("b.rst_hs", hs_b, 1);
    chk("b.rst_vs", vs_b, 1);
    chk("b.rst_blank", bl_b, 1);
    chk("b.rst_rgb", rgb_b, 0);
    chk("b.rst_addr", addr_b, 0);
    chk("b.rst_draw_x", dx_b, 0);
    chk("b.rst_draw_y", dy_b, 0);
    chk("b.rst_frame_start", fs_b, 0);
    repeat (3) step();
    rst_b = 1'b0;
    kb = -1;
    for (int i = 0; i < 320; i++) begin
      step();
      kb++;
      chk_small("b2", kb, 0, 2, 1'b0, addr_b, dx_b, dy_b, fs_b, hs_b, vs_b, bl_b, rgb_b);
    end

`ifdef VGA_TEST_PATTERN_EN
    psel_a = 2'd1;
    repeat (4) step();
    for (int i = 0; i < 900; i++) begin
      int j, h, v;
      step();
      j = kg - 2; h = j % 800; v = (j / 800) % 525;
      if (v < 480 && h < 80) chk("pat1.bar0", rgb_a, 'h000);
      if (v < 480 && h >= 560 && h < 640) chk("pat1.bar7", rgb_a, 'hFFF);
    end
    psel_a = 2'd3;
    repeat (4) step();
    for (int i = 0; i < 900; i++) begin
      int j, h, v;
      step();
      j = kg - 2; h = j % 800; v = (j / 800) % 525;
      if (v < 480 && h < 640) chk("pat3.checker", rgb_a, (((h >> 3) ^ (v >> 3)) & 1) ? 'h000 : 'hFFF);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
